// File: rtl/lsu_byte_seq.sv
// lsu_byte_seq
// Load/store sequencer between the MEM stage and a byte-wide data memory.
// Stores are split into one byte write per cycle, and the pipeline is stalled
// until the last byte is written. Loads are served combinationally from the
// four byte lanes of the addressed word, with sign or zero extension.
// Misaligned accesses and illegal funct3 codes are reported on err.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/we/funct3      MEM-stage request: valid, store flag, access type
//   req_addr, req_wdata      byte address, store data (LSB byte first)
//   stall, done, err         pipeline hold, completion pulse, error flag
//   ld_data                  extended load result (zero unless a load completes)
//   dmem_w_en/w_data/addr    byte write port and address to dmem
//   dmem_byte0..3            lanes of the aligned word containing dmem_addr
//
// state | meaning
// IDLE  | accept a request; loads, errors and SB complete here in one cycle
// WRITE | emit the remaining bytes of an SH/SW from latched copies
module lsu_byte_seq #(
    parameter int ADDR_WIDTH = 11,
    parameter int XLEN       = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [XLEN-1:0]       req_wdata,
    output logic                  stall,
    output logic                  done,
    output logic                  err,
    output logic [XLEN-1:0]       ld_data,
    output logic                  dmem_w_en,
    output logic [7:0]            dmem_w_data,
    output logic [ADDR_WIDTH-1:0] dmem_addr,
    input  logic [7:0]            dmem_byte0,
    input  logic [7:0]            dmem_byte1,
    input  logic [7:0]            dmem_byte2,
    input  logic [7:0]            dmem_byte3
);

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    state_t                state;
    logic [1:0]            cnt;
    logic [ADDR_WIDTH-1:0] base;
    logic [23:0]           wbuf;
    logic [1:0]            last;

    // Request decode (only meaningful in IDLE)
    logic       sz_byte, sz_half, sz_word;
    logic       illegal, misaligned, bad;
    logic       start_multi;

    assign sz_byte = (req_funct3[1:0] == 2'b00);
    assign sz_half = (req_funct3[1:0] == 2'b01);
    assign sz_word = (req_funct3 == 3'b010);

    // 011, 110, 111 are never legal; unsigned variants make no sense for stores.
    assign illegal = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                     (req_funct3 == 3'b111) || (req_we && req_funct3[2]);

    assign misaligned = (sz_half && req_addr[0]) ||
                        (sz_word && (req_addr[1:0] != 2'b00));

    assign bad = illegal || misaligned;

    assign start_multi = req_valid && req_we && !bad && !sz_byte;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 2'd0;
            base  <= '0;
            wbuf  <= 24'd0;
            last  <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_multi) begin
                        state <= WRITE;
                        base  <= req_addr;
                        wbuf  <= req_wdata[31:8];
                        last  <= sz_half ? 2'd1 : 2'd3;
                        cnt   <= 2'd1;
                    end
                end
                WRITE: begin
                    if (cnt == last) begin
                        state <= IDLE;
                        cnt   <= 2'd0;
                    end else begin
                        cnt <= cnt + 2'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Load lane select and extension
    logic [7:0]  lane [4];
    logic [7:0]  ld_b;
    logic [15:0] ld_h;
    logic [31:0] ld_ext;

    always_comb begin
        lane[0] = dmem_byte0;
        lane[1] = dmem_byte1;
        lane[2] = dmem_byte2;
        lane[3] = dmem_byte3;
    end

    always_comb begin
        ld_b = lane[req_addr[1:0]];
        ld_h = {lane[{req_addr[1], 1'b1}], lane[{req_addr[1], 1'b0}]};
        case (req_funct3)
            3'b000:  ld_ext = {{24{ld_b[7]}}, ld_b};
            3'b001:  ld_ext = {{16{ld_h[15]}}, ld_h};
            3'b010:  ld_ext = {dmem_byte3, dmem_byte2, dmem_byte1, dmem_byte0};
            3'b100:  ld_ext = {24'd0, ld_b};
            3'b101:  ld_ext = {16'd0, ld_h};
            default: ld_ext = 32'd0;
        endcase
    end

    // Byte of the latched store data that goes out on this WRITE cycle
    logic [7:0] wbyte;

    always_comb begin
        case (cnt)
            2'd1:    wbyte = wbuf[7:0];
            2'd2:    wbyte = wbuf[15:8];
            2'd3:    wbyte = wbuf[23:16];
            default: wbyte = 8'd0;
        endcase
    end

    // Outputs: combinational so loads and errors complete in zero cycles.
    // Everything is forced to zero while rst is high, which also suppresses
    // the pending byte write of an interrupted store.
    always_comb begin
        stall       = 1'b0;
        done        = 1'b0;
        err         = 1'b0;
        ld_data     = '0;
        dmem_w_en   = 1'b0;
        dmem_w_data = 8'd0;
        dmem_addr   = req_addr;
        if (rst) begin
            dmem_addr = '0;
        end else if (state == WRITE) begin
            dmem_w_en   = 1'b1;
            dmem_addr   = base + ADDR_WIDTH'(cnt);
            dmem_w_data = wbyte;
            if (cnt == last) begin
                done = 1'b1;
            end else begin
                stall = 1'b1;
            end
        end else if (req_valid) begin
            if (bad) begin
                err  = 1'b1;
                done = 1'b1;
            end else if (req_we) begin
                dmem_w_en   = 1'b1;
                dmem_w_data = req_wdata[7:0];
                if (sz_byte) begin
                    done = 1'b1;
                end else begin
                    stall = 1'b1;
                end
            end else begin
                done    = 1'b1;
                ld_data = XLEN'(ld_ext);
            end
        end
    end

endmodule

// File: doc/lsu_byte_seq.md
# lsu_byte_seq

Load/store sequencer between the pipeline MEM stage and the 8-bit-wide `dmem` byte array. It splits SB/SH/SW stores into one byte write per cycle and stalls the pipeline until the last byte is written. It serves LB/LH/LW/LBU/LHU loads combinationally from the four byte lanes of the addressed word, with sign or zero extension. It also flags misaligned accesses and illegal funct3 encodings.

## Interface
- `ADDR_WIDTH`, default 11: byte address width; matches `dmem`.
- `XLEN`, default 32: pipeline data width; fixed at 32.

Ports (clock and reset first):
- `clk`  in  1  sole clock.
- `rst`  in  1  reset, synchronous, active-high.
- `req_valid`  in  1  MEM-stage memory request present.
- `req_we`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  access type: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `req_addr`  in  ADDR_WIDTH  byte address.
- `req_wdata`  in  XLEN  store data; bytes taken from the LSB upward.
- `stall`  out  1  pipeline must hold the MEM request.
- `done`  out  1  one-cycle pulse when the request completes.
- `err`  out  1  misaligned address or illegal funct3 (for loads and stores); no memory write occurs.
- `ld_data`  out  XLEN  extended load result; valid when `done` is high and `req_we` is 0.
- `dmem_w_en`  out  1  byte write enable to `dmem`.
- `dmem_w_data`  out  8  byte to write.
- `dmem_addr`  out  ADDR_WIDTH  byte address to `dmem`.
- `dmem_byte0..dmem_byte3`  in  8 each  lanes 0..3 of the aligned word containing `dmem_addr`.

## Operation
- **Size rule:**
  - N = 1 for B/BU, 2 for H/HU, 4 for W.
  - Alignment requires `addr[0]`=0 for H/HU and `addr[1:0]`=0 for W.
  - funct3 values 011, 110 and 111 are illegal; for stores, 100 and 101 are also illegal.
- **FSM states:** IDLE and WRITE. Registers:
  - `cnt` (2 bits)
  - `base` (ADDR_WIDTH)
  - `wbuf` (24 bits: bytes 1..3 of `req_wdata`)
  - `last` (2 bits, = N-1)
- **IDLE, no request** (`req_valid`=0): `dmem_addr`=`req_addr`, `dmem_w_en`=0, `stall`=0, `done`=0, `err`=0.
- **IDLE, load:**
  - `dmem_addr`=`req_addr`; `done`=1 in the same cycle.
  - Lane select = `addr[1:0]` for B/BU and `{addr[1],0}` for H/HU; halfword is little-endian (low byte in the lower lane).
  - Extension: B/H sign-extend, BU/HU zero-extend; W returns `{byte3,byte2,byte1,byte0}`.
- **IDLE, error** (misaligned or illegal): `err`=1, `done`=1, `ld_data`=0, `dmem_w_en`=0, `stall`=0, no state change.
- **IDLE, legal store:**
  - Writes byte 0 this cycle: `dmem_w_en`=1, `dmem_addr`=`req_addr`, `dmem_w_data`=`req_wdata[7:0]`.
  - If N=1: `done`=1, `stall`=0, stay in IDLE.
  - Else: `stall`=1; latch `base`=`req_addr`, `wbuf`=`req_wdata[31:8]`, `last`=N-1, `cnt`=1; go to WRITE.
- **WRITE:**
  - Outputs: `dmem_w_en`=1, `dmem_addr`=`base`+`cnt`, `dmem_w_data`=`wbuf` byte (`cnt`-1).
  - If `cnt`==`last`: `stall`=0, `done`=1, go to IDLE.
  - Else: `stall`=1, `cnt`+1.
- **Request inputs in WRITE:** all `req_*` inputs are ignored; only latched copies are used.
- **Address arithmetic:** aligned stores never cross a word, so `base`+`cnt` never wraps. The add is ADDR_WIDTH bits wide with carry discarded.
- `ld_data`=0 whenever `done`=0, or on a store.

## Timing
- **Reset:** all outputs are 0 during and after reset (`stall`, `done`, `err`, `ld_data`, `dmem_w_en`, `dmem_w_data`, `dmem_addr`). State = IDLE, `cnt`=0, `base`/`wbuf`/`last`=0.
- **Load and error latency:** 0 cycles (combinational; `dmem` read is asynchronous).
- **Store latency:** N cycles. SB is 1 cycle with no stall, SH is 2 cycles (stall high in cycle 1), SW is 4 cycles (stall high in cycles 1–3). `done` is asserted in cycle N.
- **Next request:** accepted in the cycle after `done`. With `req_valid` held continuously, back-to-back stores incur no bubbles.
- **Reset mid-sequence:** the remaining bytes are not written. `dmem_w_en` is 0 in the reset cycle and the FSM returns to IDLE. Already-written bytes persist.
- **Stall contract:** `stall` depends combinationally on `req_*` only in IDLE. The upstream stage must not rely on `stall` to gate its own `req_valid`.

## Test plan
- **SW:** SW 0xDEADBEEF to 0x010 → writes (0x010,EF), (0x011,BE), (0x012,AD), (0x013,DE) on 4 consecutive cycles; `stall`=1,1,1,0; `done` pulses in cycle 4. A following LW 0x010 returns 0xDEADBEEF.
- **SH then loads:** SH 0x8001 to 0x022 → 2 writes, `stall`=1,0. LH 0x022 → 0xFFFF8001; LHU 0x022 → 0x00008001.
- **SB then loads:** SB 0x80 to 0x033 → 1 write, no stall. LB 0x033 → 0xFFFFFF80; LBU 0x033 → 0x00000080.
- **Misaligned/illegal:** SW to 0x041, LH at 0x043, funct3=011 → `err`=1, `done`=1, no `dmem_w_en`, `ld_data`=0, no stall.
- **Reset mid-SW:** SW 0x11223344 to 0x050, with `rst` asserted in cycle 3 → only 0x050=44 and 0x051=33 are written; `stall`=0 and the FSM is in IDLE after reset. A new SB completes normally.
- **Ignored inputs:** during an SW in WRITE, change `req_addr`/`req_wdata` → the written bytes still come from the latched values.
